// File: rtl/data_memory_sized.sv
// Word-organised data memory with byte/half/word access, valid/ready request port,
// registered read response and post-reset init sequencer. Optional fault checks: DMEM_ERR_EN.
module data_memory_sized #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INIT_MODE  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic                  resp_valid,
    output logic [31:0]           read_data,
    output logic                  resp_err,
    output logic                  init_busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   cnt;
    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               fault;
    logic               store_we;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         lane;
    logic [3:0]         be;
    logic [31:0]        wdata;

    logic [31:0]        rd_word;
    logic               rsp_zero;
    logic [1:0]         rsp_size;
    logic [1:0]         rsp_lane;
    logic               rsp_unsigned;
    logic               unused_addr;

    assign req_ready = (state == ST_RUN);
    assign init_busy = (state == ST_INIT);
    assign accept    = req_valid & req_ready;
    assign idx       = address[IDX_W+1:2];
    assign lane      = address[1:0];
    assign store_we  = accept & req_write & ~fault;
    assign unused_addr = ^address;

`ifdef DMEM_ERR_EN
    logic misaligned;
    logic out_of_range;
    assign misaligned   = (req_size == 2'b01 && address[0])
                        || (req_size == 2'b10 && address[1:0] != 2'b00)
                        || (req_size == 2'b11);
    assign out_of_range = {1'b0, address} >= (ADDR_WIDTH+1)'(DEPTH * 4);
    assign fault        = misaligned | out_of_range;
`else
    assign fault = 1'b0;
`endif

    // Store data is replicated across lanes; the byte enables pick the addressed ones.
    always_comb begin
        be    = 4'b1111;
        wdata = write_data;
        case (req_size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{write_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = write_data;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
                state <= ST_RUN;
            end
        end
    end

    // Array port: init fill or byte-enabled store, plus registered read on accept.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[cnt] <= (INIT_MODE != 0) ? 32'(cnt) : '0;
        end else if (store_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (accept) begin
            rd_word <= mem[idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            rsp_zero     <= 1'b1;
            rsp_size     <= '0;
            rsp_lane     <= '0;
            rsp_unsigned <= 1'b0;
        end else begin
            resp_valid <= accept;
            resp_err   <= accept & fault;
            if (accept) begin
                rsp_zero     <= req_write | fault;
                rsp_size     <= req_size;
                rsp_lane     <= lane;
                rsp_unsigned <= req_unsigned;
            end
        end
    end

    // Lane select and extension from the held response state, so read_data is stable between responses.
    always_comb begin
        logic [7:0]  bsel;
        logic [15:0] hsel;
        bsel      = rd_word[{rsp_lane, 3'b000} +: 8];
        hsel      = rsp_lane[1] ? rd_word[31:16] : rd_word[15:0];
        read_data = '0;
        if (!rsp_zero) begin
            case (rsp_size)
                2'b00:   read_data = rsp_unsigned ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
                2'b01:   read_data = rsp_unsigned ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
                default: read_data = rd_word;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// Randomised self-checking bench for data_memory_sized against a byte-array reference model.
module tb_data_memory_sized;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        resp_err;
    logic        init_busy;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [7:0]  ref_b [NBYTES];
    logic [31:0] last_exp = '0;
    logic [31:0] last_rd = '0;
    logic        last_err = 1'b0;

    data_memory_sized #(
        .DEPTH(DEPTH),
        .ADDR_WIDTH(32),
        .INIT_MODE(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .address(address),
        .write_data(write_data),
        .resp_valid(resp_valid),
        .read_data(read_data),
        .resp_err(resp_err),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Memory viewed as bytes: word i initialised to the value i, little-endian.
    function automatic void model_init();
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int k = 0; k < 4; k++) begin
                ref_b[4*i + k] = 8'((i >> (8*k)) & 255);
            end
        end
    endfunction

    function automatic int unsigned access_bytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic model_fault(input logic [1:0] sz, input logic [31:0] addr);
`ifdef DMEM_ERR_EN
        if (addr >= NBYTES) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        if (addr % access_bytes(sz) != 0) return 1'b1;
        return 1'b0;
`else
        return (sz == 2'd3) && (addr > 32'hFFFF_FFFF);
`endif
    endfunction

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic un, input logic [31:0] addr, input logic [31:0] wd);
        int unsigned n;
        int unsigned base;
        logic        f;
        logic [31:0] v;
        n    = access_bytes(sz);
        base = ((addr % NBYTES) / n) * n;
        f    = model_fault(sz, addr);
        v    = '0;
        if (!f) begin
            if (wr) begin
                for (int k = 0; k < int'(n); k++) ref_b[base + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < int'(n); k++) v[8*k +: 8] = ref_b[base + k];
                if (!un && n < 4 && v[8*n - 1]) begin
                    for (int k = int'(n); k < 4; k++) v[8*k +: 8] = 8'hFF;
                end
            end
        end
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = un;
        address      = addr;
        write_data   = wd;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".data"}, read_data, v);
        check({tag, ".err"}, 32'(resp_err), 32'(f));
        last_exp = v;
        last_rd  = read_data;
        last_err = resp_err;
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".novalid"}, 32'(resp_valid), 32'd0);
        check({tag, ".hold"}, read_data, last_exp);
    endtask

    // Runs while init_busy; returns cycles counted and whether any response leaked out.
    task automatic wait_init(output int n, output logic saw_resp);
        n = 0;
        saw_resp = 1'b0;
        while (init_busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (resp_valid) saw_resp = 1'b1;
        end
    endtask

    initial begin
        int          n;
        logic        leak;
        logic [1:0]  sz;
        logic [31:0] addr;

        repeat (3) @(posedge clk);
        #1;
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.read_data", read_data, 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.init_busy", 32'(init_busy), 32'd1);

        @(negedge clk);
        reset = 1'b0;
        wait_init(n, leak);
        check("init.cycles", 32'(n), 32'd64);
        check("init.ready", 32'(req_ready), 32'd1);
        model_init();

        do_req("w14", 1'b0, 2'd2, 1'b0, 32'h14, '0);
        check("plan.w14", last_rd, 32'h0000_0005);
        do_req("sb21", 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00A5);
        do_req("lb21", 1'b0, 2'd0, 1'b0, 32'h21, '0);
        check("plan.lb21", last_rd, 32'hFFFF_FFA5);
        do_req("lbu21", 1'b0, 2'd0, 1'b1, 32'h21, '0);
        check("plan.lbu21", last_rd, 32'h0000_00A5);
        do_req("lw20", 1'b0, 2'd2, 1'b0, 32'h20, '0);
        check("plan.lw20", last_rd, 32'h0000_A508);
        do_req("sh32", 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000_8001);
        do_req("lh32", 1'b0, 2'd1, 1'b0, 32'h32, '0);
        check("plan.lh32", last_rd, 32'hFFFF_8001);
        do_req("lw30", 1'b0, 2'd2, 1'b0, 32'h30, '0);
        check("plan.lw30", last_rd, 32'h8001_000C);
        do_req("sw40", 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF);
        do_req("lw40", 1'b0, 2'd2, 1'b0, 32'h40, '0);
        check("plan.lw40", last_rd, 32'hDEAD_BEEF);
        idle_cycle("idle0");

`ifdef DMEM_ERR_EN
        do_req("errw06", 1'b0, 2'd2, 1'b0, 32'h06, '0);
        check("plan.err06", 32'(last_err), 32'd1);
        do_req("errs100", 1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678);
        check("plan.err100", 32'(last_err), 32'd1);
        do_req("lw0", 1'b0, 2'd2, 1'b0, 32'h0, '0);
        check("plan.lw0", last_rd, 32'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                idle_cycle("rnd.idle");
            end else begin
                sz = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) addr = $urandom;
                else addr = 32'($urandom_range(0, NBYTES - 1));
                if ($urandom_range(0, 1) == 1) addr = (addr / access_bytes(sz)) * access_bytes(sz);
                do_req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom);
            end
        end

        // Reset lands right after a load is accepted: its response must never appear.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size = 2'd2;
        address = 32'h20;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst.resp_valid", 32'(resp_valid), 32'd0);
        check("midrst.init_busy", 32'(init_busy), 32'd1);
        check("midrst.req_ready", 32'(req_ready), 32'd0);
        check("midrst.read_data", read_data, 32'd0);
        req_write = 1'b1;
        write_data = 32'hFFFF_FFFF;
        @(negedge clk);
        reset = 1'b0;
        wait_init(n, leak);
        req_valid = 1'b0;
        check("reinit.cycles", 32'(n), 32'd64);
        check("reinit.noresp", 32'(leak), 32'd0);
        model_init();
        last_exp = '0;
        do_req("reinit.lw20", 1'b0, 2'd2, 1'b0, 32'h20, '0);
        check("plan.reinit20", last_rd, 32'h0000_0008);
        idle_cycle("idle1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
